// File: rtl/multdiv_stall_controller_if.sv
// -----------------------------------------------------------------------------
// multdiv_stall_controller_if
//   Bundles the signals between the DX/XM pipeline, the multdiv unit and the
//   multdiv stall controller.
//   slave  : the controller. It sees the DX instruction and the multdiv
//            status, and drives the start pulses, stall and XM result.
//   master : the pipeline/multdiv side. It is the mirror image of slave.
// -----------------------------------------------------------------------------
interface multdiv_stall_controller_if;
  logic [31:0] DX_Latch_Instr;
  logic        multdiv_resultRDY;
  logic        multdiv_exception;
  logic [31:0] multdiv_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        md_stall;
  logic        md_valid;
  logic [31:0] md_result;
  logic [4:0]  md_rd;
  logic        md_exception;
  logic        md_is_div;

  modport slave (
    input  DX_Latch_Instr, multdiv_resultRDY, multdiv_exception, multdiv_result,
    output ctrl_MULT, ctrl_DIV, md_stall, md_valid, md_result, md_rd,
           md_exception, md_is_div
  );

  modport master (
    output DX_Latch_Instr, multdiv_resultRDY, multdiv_exception, multdiv_result,
    input  ctrl_MULT, ctrl_DIV, md_stall, md_valid, md_result, md_rd,
           md_exception, md_is_div
  );
endinterface

// File: rtl/multdiv_stall_controller.sv
// -----------------------------------------------------------------------------
// multdiv_stall_controller
//   Sequences the multi-cycle multiply/divide unit. A mul/div R-type in DX
//   raises the stall at once. The controller then issues a one-cycle start
//   pulse and waits for the unit's ready strobe, or for a timeout. Finally it
//   presents result, rd and exception to XM for exactly one cycle.
// Ports
//   clock    : pipeline clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport carrying the DX instruction, multdiv status,
//              start pulses (ctrl_MULT/ctrl_DIV), md_stall and the XM result
//              (md_valid, md_result, md_rd, md_exception, md_is_div)
// Parameter
//   MAX_CYCLES : START+BUSY cycle bound before a forced timeout exception
// -----------------------------------------------------------------------------
module multdiv_stall_controller #(
  parameter int MAX_CYCLES = 40
) (
  input  logic                          clock,
  input  logic                          reset_n,
  multdiv_stall_controller_if.slave     bus
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES);

  localparam logic [4:0] ALU_MULT = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [31:0]       result_q;
  logic [4:0]        rd_q;
  logic              exc_q;
  logic              is_div_q;

  logic [4:0] opcode;
  logic [4:0] aluop;
  logic       is_md;
  logic       dec_is_div;

  assign opcode     = bus.DX_Latch_Instr[31:27];
  assign aluop      = bus.DX_Latch_Instr[6:2];
  assign is_md      = (opcode == 5'd0) && ((aluop == ALU_MULT) || (aluop == ALU_DIV));
  assign dec_is_div = (aluop == ALU_DIV);

  // Only opcode, rd and the ALU op field matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.DX_Latch_Instr[21:7], bus.DX_Latch_Instr[1:0]};

  // The counter saturates at all-ones. Because BUSY exits at CNT_LIMIT, it
  // never reaches saturation in normal use, and it can never wrap.
  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      exc_q    <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_md) begin
            rd_q     <= bus.DX_Latch_Instr[26:22];
            is_div_q <= dec_is_div;
            cnt_q    <= '0;
            state_q  <= START;
          end
        end
        // The unit has only just been told to start, so any ready strobe
        // seen in this cycle cannot belong to this op.
        START: begin
          cnt_q   <= cnt_d;
          state_q <= BUSY;
        end
        // A ready strobe takes priority over a timeout that lands in the
        // same cycle.
        BUSY: begin
          cnt_q <= cnt_d;
          if (bus.multdiv_resultRDY) begin
            result_q <= bus.multdiv_result;
            exc_q    <= bus.multdiv_exception;
            state_q  <= DONE;
          end else if (cnt_q == CNT_LIMIT) begin
            result_q <= '0;
            exc_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        // In DONE the op leaves DX, so the decode is not looked at here. A
        // following mul/div is picked up by the next IDLE cycle.
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The pulse outputs decode the state register directly. Reset forces IDLE,
  // so they drop asynchronously with reset_n. The is_md term is gated with
  // reset_n, which keeps the stall low while reset is held.
  assign bus.ctrl_MULT    = (state_q == START) && !is_div_q;
  assign bus.ctrl_DIV     = (state_q == START) &&  is_div_q;
  assign bus.md_valid     = (state_q == DONE);
  assign bus.md_stall     = (reset_n && (state_q == IDLE) && is_md) ||
                            (state_q == START) || (state_q == BUSY);
  assign bus.md_result    = result_q;
  assign bus.md_rd        = rd_q;
  assign bus.md_exception = exc_q;
  assign bus.md_is_div    = is_div_q;

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_multdiv_stall_controller
//   Directed bench for multdiv_stall_controller with MAX_CYCLES = 40.
//   Inputs change 1 time unit after a rising edge. Outputs are read 1 time
//   unit later, so each loop index corresponds to one pipeline cycle.
// -----------------------------------------------------------------------------
module tb_multdiv_stall_controller;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  multdiv_stall_controller_if ifc ();

  multdiv_stall_controller #(.MAX_CYCLES(40)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] op);
    return {5'd0, rd, 5'd1, 5'd2, 5'd0, op, 2'b00};
  endfunction

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic set_md(input logic rdy, input logic exc, input logic [31:0] res);
    ifc.multdiv_resultRDY = rdy;
    ifc.multdiv_exception = exc;
    ifc.multdiv_result    = res;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [3:0] obs;
    reset_n = 1'b0;
    ifc.DX_Latch_Instr = rtype(5'd5, 5'd6);
    set_md(1'b1, 1'b1, JUNK);
    repeat (2) @(posedge clock);
    #2;
    obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: stall/mult/div/valid=%b expected 0000", obs);
    end
    vectors++;
    if ({ifc.md_result, ifc.md_rd, ifc.md_exception, ifc.md_is_div} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_regs: result=%h rd=%0d exc=%b div=%b expected all 0",
               ifc.md_result, ifc.md_rd, ifc.md_exception, ifc.md_is_div);
    end
    ifc.DX_Latch_Instr = NOP;
    set_md(1'b0, 1'b0, 32'd0);
    reset_n = 1'b1;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_non_md;
    logic [3:0]  obs;
    logic [31:0] instr;
    for (int c = 0; c < 6; c++) begin
      // add (ALU op 0) then lw whose immediate puts 6 into bits [6:2]
      instr = (c < 3) ? rtype(5'd3, 5'd0) : {5'b01000, 5'd5, 5'd1, 17'h00018};
      ifc.DX_Latch_Instr = instr;
      set_md(c[0], 1'b0, JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL non_md cyc %0d: stall/mult/div/valid=%b expected 0000", c, obs);
      end
      next_cycle();
    end
    ifc.DX_Latch_Instr = NOP;
    set_md(1'b0, 1'b0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // mult rd=5. RDY is also pulsed in cycles 0 and 1, where it must be
  // ignored. The real RDY comes in cycle 33 and DONE follows in cycle 34.
  task automatic test_mult;
    logic [3:0] obs, exp;
    ifc.DX_Latch_Instr = rtype(5'd5, 5'd6);
    for (int c = 0; c <= 34; c++) begin
      set_md((c == 33) || (c <= 1), 1'b0, (c == 33) ? 32'h0000_0C00 : JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      exp = {(c <= 33), (c == 1), 1'b0, (c == 34)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mult cyc %0d: stall/mult/div/valid=%b expected %b", c, obs, exp);
      end
      if (c == 34) begin
        vectors++;
        if ({ifc.md_result, ifc.md_rd, ifc.md_is_div, ifc.md_exception} !==
            {32'h0000_0C00, 5'd5, 1'b0, 1'b0}) begin
          miscompares++;
          $display("FAIL mult_done: result=%h rd=%0d div=%b exc=%b expected 00000c00 5 0 0",
                   ifc.md_result, ifc.md_rd, ifc.md_is_div, ifc.md_exception);
        end
      end
      next_cycle();
    end
    ifc.DX_Latch_Instr = NOP;
    set_md(1'b0, 1'b0, 32'd0);
    #1;
    vectors++;
    if ({ifc.md_stall, ifc.md_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL mult_after: stall/valid=%b expected 00", {ifc.md_stall, ifc.md_valid});
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // RDY never arrives, so DONE lands in cycle 42 with a forced exception.
  task automatic test_timeout;
    logic [3:0] obs, exp;
    ifc.DX_Latch_Instr = rtype(5'd3, 5'd6);
    for (int c = 0; c <= 42; c++) begin
      set_md(1'b0, 1'b0, JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      exp = {(c <= 41), (c == 1), 1'b0, (c == 42)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL timeout cyc %0d: stall/mult/div/valid=%b expected %b", c, obs, exp);
      end
      if (c == 42) begin
        vectors++;
        if ({ifc.md_result, ifc.md_rd, ifc.md_exception} !== {32'd0, 5'd3, 1'b1}) begin
          miscompares++;
          $display("FAIL timeout_done: result=%h rd=%0d exc=%b expected 00000000 3 1",
                   ifc.md_result, ifc.md_rd, ifc.md_exception);
        end
      end
      next_cycle();
    end
    ifc.DX_Latch_Instr = NOP;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // RDY comes in cycle 41, the same cycle the timeout would fire. The ready
  // strobe wins, so this is a normal completion with no exception.
  task automatic test_rdy_at_limit;
    logic [3:0] obs, exp;
    ifc.DX_Latch_Instr = rtype(5'd9, 5'd7);
    for (int c = 0; c <= 42; c++) begin
      set_md(c == 41, 1'b0, (c == 41) ? 32'h0000_1234 : JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      exp = {(c <= 41), 1'b0, (c == 1), (c == 42)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rdy_limit cyc %0d: stall/mult/div/valid=%b expected %b", c, obs, exp);
      end
      if (c == 42) begin
        vectors++;
        if ({ifc.md_result, ifc.md_rd, ifc.md_is_div, ifc.md_exception} !==
            {32'h0000_1234, 5'd9, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL rdy_limit_done: result=%h rd=%0d div=%b exc=%b expected 00001234 9 1 0",
                   ifc.md_result, ifc.md_rd, ifc.md_is_div, ifc.md_exception);
        end
      end
      next_cycle();
    end
    ifc.DX_Latch_Instr = NOP;
    set_md(1'b0, 1'b0, 32'd0);
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_div_by_zero;
    logic [3:0] obs, exp;
    ifc.DX_Latch_Instr = rtype(5'd7, 5'd7);
    for (int c = 0; c <= 34; c++) begin
      set_md(c == 33, c == 33, (c == 33) ? 32'h0000_0000 : JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      exp = {(c <= 33), 1'b0, (c == 1), (c == 34)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL div0 cyc %0d: stall/mult/div/valid=%b expected %b", c, obs, exp);
      end
      if (c == 34) begin
        vectors++;
        if ({ifc.md_rd, ifc.md_is_div, ifc.md_exception} !== {5'd7, 1'b1, 1'b1}) begin
          miscompares++;
          $display("FAIL div0_done: rd=%0d div=%b exc=%b expected 7 1 1",
                   ifc.md_rd, ifc.md_is_div, ifc.md_exception);
        end
      end
      next_cycle();
    end
    ifc.DX_Latch_Instr = NOP;
    set_md(1'b0, 1'b0, 32'd0);
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // mult rd=4 gets RDY in cycle 4 and completes in cycle 5. div rd=12 enters
  // DX in cycle 6 (the IDLE cycle) and completes in cycle 9.
  task automatic test_back_to_back;
    logic [3:0] obs, exp;
    for (int c = 0; c <= 10; c++) begin
      ifc.DX_Latch_Instr = (c <= 5) ? rtype(5'd4, 5'd6) :
                           (c <= 9) ? rtype(5'd12, 5'd7) : NOP;
      set_md((c == 4) || (c == 8), 1'b0,
             (c == 4) ? 32'h0000_0011 : (c == 8) ? 32'h0000_0022 : JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      exp = {((c <= 4) || ((c >= 6) && (c <= 8))), (c == 1), (c == 7),
             ((c == 5) || (c == 9))};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL b2b cyc %0d: stall/mult/div/valid=%b expected %b", c, obs, exp);
      end
      if (c == 5) begin
        vectors++;
        if ({ifc.md_result, ifc.md_rd, ifc.md_is_div} !== {32'h0000_0011, 5'd4, 1'b0}) begin
          miscompares++;
          $display("FAIL b2b_first: result=%h rd=%0d div=%b expected 00000011 4 0",
                   ifc.md_result, ifc.md_rd, ifc.md_is_div);
        end
      end
      if (c == 9) begin
        vectors++;
        if ({ifc.md_result, ifc.md_rd, ifc.md_is_div} !== {32'h0000_0022, 5'd12, 1'b1}) begin
          miscompares++;
          $display("FAIL b2b_second: result=%h rd=%0d div=%b expected 00000022 12 1",
                   ifc.md_result, ifc.md_rd, ifc.md_is_div);
        end
      end
      next_cycle();
    end
    set_md(1'b0, 1'b0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Reset is asserted between clock edges while the op is in BUSY (cycle 10).
  // A stray RDY after release, with no md op in DX, must not produce md_valid.
  task automatic test_reset_mid_op;
    logic [3:0] obs;
    ifc.DX_Latch_Instr = rtype(5'd6, 5'd6);
    for (int c = 0; c <= 10; c++) begin
      set_md(1'b0, 1'b0, JUNK);
      #1;
      if (c == 10) begin
        obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
        vectors++;
        if (obs !== 4'b1000) begin
          miscompares++;
          $display("FAIL rst_mid_busy: stall/mult/div/valid=%b expected 1000", obs);
        end
        reset_n = 1'b0;
        #1;
        obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
        vectors++;
        if (obs !== 4'b0000) begin
          miscompares++;
          $display("FAIL rst_mid_ctrl: stall/mult/div/valid=%b expected 0000", obs);
        end
        vectors++;
        if ({ifc.md_result, ifc.md_rd, ifc.md_exception, ifc.md_is_div} !== 39'd0) begin
          miscompares++;
          $display("FAIL rst_mid_regs: result=%h rd=%0d exc=%b div=%b expected all 0",
                   ifc.md_result, ifc.md_rd, ifc.md_exception, ifc.md_is_div);
        end
      end else begin
        next_cycle();
      end
    end
    ifc.DX_Latch_Instr = NOP;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      set_md(1'b1, 1'b1, JUNK);
      #1;
      obs = {ifc.md_stall, ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.md_valid};
      vectors++;
      if ((obs !== 4'b0000) || (ifc.md_result !== 32'd0)) begin
        miscompares++;
        $display("FAIL rst_stray_rdy cyc %0d: stall/mult/div/valid=%b result=%h expected 0000 00000000",
                 c, obs, ifc.md_result);
      end
      next_cycle();
    end
    set_md(1'b0, 1'b0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    ifc.DX_Latch_Instr = NOP;
    set_md(1'b0, 1'b0, 32'd0);
    test_reset();
    test_non_md();
    test_mult();
    test_timeout();
    test_rdy_at_limit();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
